// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - Arbiter state encoding (legacy-compatible constant encoding).
//   - ALU opcode constants understood by the shared ALU.
//   - Default operand/result width of the shared ALU.
package alu_arb_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;

  // Arbiter states
  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  // ALU opcodes
  localparam logic [4:0] ADD = 5'd0;
  localparam logic [4:0] SUB = 5'd1;
  localparam logic [4:0] AND = 5'd2;
  localparam logic [4:0] OR  = 5'd3;
  localparam logic [4:0] SLL = 5'd4;
  localparam logic [4:0] SRA = 5'd5;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational grant decision for the ALU arbiter.
// Ports:
//   state      in  2  current arbiter state (ARB / LOCK0 / LOCK1)
//   lastGrant  in  1  requester that won the most recent transfer
//   valid0/1   in  1  requester valid flags
//   grant0/1   out 1  grant, already qualified with the matching valid
module alu_arb_grant
  import alu_arb_pkg::*;
(
  input  logic [1:0] state,
  input  logic       lastGrant,
  input  logic       valid0,
  input  logic       valid1,
  output logic       grant0,
  output logic       grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      LOCK0: grant0 = valid0;
      LOCK1: grant1 = valid1;
      default: begin
        // Tie goes to the requester that did not win last time.
        if (valid0 && valid1) begin
          grant0 = lastGrant;
          grant1 = !lastGrant;
        end else begin
          grant0 = valid0;
          grant1 = valid1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and
// the mult/div sequencer (requester 1). Round-robin per cycle with an
// optional per-requester lock; ALU outputs are registered and returned to
// the winner one cycle after the transfer.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   reqN_valid/lock/opcode/shamt/opA/opB  requester op fields (N = 0, 1)
//   reqN_ready                   op accepted this cycle
//   alu_opA/opB/opcode/shamt     drive the ALU from the granted request
//   alu_result/ne/lt/ovf         ALU outputs
//   rsp_valid/id/result/ne/lt/ovf registered response to the winner
// Optional (macro ALU_ARB_STATS_EN):
//   stat_clear                   synchronous clear of the grant counters
//   stat_grant0/1                saturating per-requester grant counters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
`ifdef ALU_ARB_STATS_EN
  , parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_lock,
  input  logic [4:0]            req0_opcode,
  input  logic [4:0]            req0_shamt,
  input  logic [DATA_WIDTH-1:0] req0_opA,
  input  logic [DATA_WIDTH-1:0] req0_opB,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_lock,
  input  logic [4:0]            req1_opcode,
  input  logic [4:0]            req1_shamt,
  input  logic [DATA_WIDTH-1:0] req1_opA,
  input  logic [DATA_WIDTH-1:0] req1_opB,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] alu_opA,
  output logic [DATA_WIDTH-1:0] alu_opB,
  output logic [4:0]            alu_opcode,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_ne,
  input  logic                  alu_lt,
  input  logic                  alu_ovf,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_ne,
  output logic                  rsp_lt,
  output logic                  rsp_ovf
`ifdef ALU_ARB_STATS_EN
  , input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_grant0,
  output logic [STAT_WIDTH-1:0] stat_grant1
`endif
);

  logic [1:0] state;
  logic [1:0] stateNext;
  logic       lastGrant;
  logic       grant0;
  logic       grant1;
  logic       xfer;
  logic       winner;
  logic       winLock;

  alu_arb_grant grantLogic (
    .state    (state),
    .lastGrant(lastGrant),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign winner     = grant1;
  assign winLock    = grant1 ? req1_lock : req0_lock;

  always_comb begin
    alu_opA    = '0;
    alu_opB    = '0;
    alu_opcode = '0;
    alu_shamt  = '0;
    if (grant0) begin
      alu_opA    = req0_opA;
      alu_opB    = req0_opB;
      alu_opcode = req0_opcode;
      alu_shamt  = req0_shamt;
    end else if (grant1) begin
      alu_opA    = req1_opA;
      alu_opB    = req1_opB;
      alu_opcode = req1_opcode;
      alu_shamt  = req1_shamt;
    end
  end

  // In a lock state only the owner can be granted, so winLock is the owner's.
  always_comb begin
    stateNext = state;
    case (state)
      ARB:          if (xfer && winLock)  stateNext = grant1 ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (xfer && !winLock) stateNext = ARB;
      default:      stateNext = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB;
      lastGrant  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ne     <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state     <= stateNext;
      rsp_valid <= xfer;
      if (xfer) begin
        lastGrant  <= winner;
        rsp_id     <= winner;
        rsp_result <= alu_result;
        rsp_ne     <= alu_ne;
        rsp_lt     <= alu_lt;
        rsp_ovf    <= alu_ovf;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || stat_clear) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else begin
      if (grant0 && (stat_grant0 != '1)) stat_grant0 <= stat_grant0 + STAT_WIDTH'(1);
      if (grant1 && (stat_grant1 != '1)) stat_grant1 <= stat_grant1 + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The bench also plays the ALU.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int STAT_W = 2;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2,
                         OP_OR = 5'd3, OP_SLL = 5'd4, OP_SRA = 5'd5;

  typedef struct packed {
    logic [DW-1:0] r;
    logic          ne;
    logic          lt;
    logic          ovf;
  } aluOut_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 0, req0_lock = 0, req1_valid = 0, req1_lock = 0;
  logic [4:0] req0_opcode = '0, req0_shamt = '0, req1_opcode = '0, req1_shamt = '0;
  logic [DW-1:0] req0_opA = '0, req0_opB = '0, req1_opA = '0, req1_opB = '0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] alu_opA, alu_opB, alu_result;
  logic [4:0] alu_opcode, alu_shamt;
  logic alu_ne, alu_lt, alu_ovf;
  logic rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_ovf;
  logic [DW-1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic stat_clear = 1'b0;
  logic [STAT_W-1:0] stat_grant0, stat_grant1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_arbiter #(
    .DATA_WIDTH(DW)
`ifdef ALU_ARB_STATS_EN
    , .STAT_WIDTH(STAT_W)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_opcode(req0_opcode),
    .req0_shamt(req0_shamt), .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_opcode(req1_opcode),
    .req1_shamt(req1_shamt), .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_ready(req1_ready),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ne(rsp_ne), .rsp_lt(rsp_lt), .rsp_ovf(rsp_ovf)
`ifdef ALU_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  // Reference ALU behaviour: used both to emulate the ALU and to predict responses.
  function automatic aluOut_t aluRef(logic [4:0] op, logic [4:0] sh, logic [DW-1:0] a, logic [DW-1:0] b);
    aluOut_t o;
    o = '0;
    case (op)
      OP_ADD: begin o.r = a + b; o.ovf = (a[DW-1] == b[DW-1]) && (o.r[DW-1] != a[DW-1]); end
      OP_SUB: begin o.r = a - b; o.ovf = (a[DW-1] != b[DW-1]) && (o.r[DW-1] != a[DW-1]); end
      OP_AND: o.r = a & b;
      OP_OR:  o.r = a | b;
      OP_SLL: o.r = a << sh;
      OP_SRA: o.r = $signed(a) >>> sh;
      default: o.r = '0;
    endcase
    o.ne = (a != b);
    o.lt = ($signed(a) < $signed(b));
    return o;
  endfunction

  aluOut_t aluNow;
  always_comb begin
    aluNow     = aluRef(alu_opcode, alu_shamt, alu_opA, alu_opB);
    alu_result = aluNow.r;
    alu_ne     = aluNow.ne;
    alu_lt     = aluNow.lt;
    alu_ovf    = aluNow.ovf;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int      lockOwner = -1;   // -1: nobody holds the ALU
  int      lastWin   = 1;
  logic    started   = 1'b0;
  logic    expValid  = 1'b0;
  logic    expId     = 1'b0;
  aluOut_t expRes    = '0;
  int      expStat0  = 0;
  int      expStat1  = 0;

  function automatic logic [1:0] modelGrant();  // {grant1, grant0}
    if (lockOwner == 0) return {1'b0, req0_valid};
    if (lockOwner == 1) return {req1_valid, 1'b0};
    if (req0_valid && req1_valid) return (lastWin == 0) ? 2'b10 : 2'b01;
    return {req1_valid, req0_valid};
  endfunction

  always @(posedge clock) begin
    logic [1:0] g;
    logic wl;
    g = modelGrant();
    if (reset) begin
      started   <= 1'b1;
      lockOwner <= -1;
      lastWin   <= 1;
      expValid  <= 1'b0;
      expId     <= 1'b0;
      expRes    <= '0;
      expStat0  <= 0;
      expStat1  <= 0;
    end else begin
      expValid <= |g;
      if (|g) begin
        wl = g[1] ? req1_lock : req0_lock;
        expId   <= g[1];
        expRes  <= g[1] ? aluRef(req1_opcode, req1_shamt, req1_opA, req1_opB)
                        : aluRef(req0_opcode, req0_shamt, req0_opA, req0_opB);
        lastWin <= g[1] ? 1 : 0;
        if (lockOwner == -1 && wl) lockOwner <= g[1] ? 1 : 0;
        if (lockOwner != -1 && !wl) lockOwner <= -1;
      end
`ifdef ALU_ARB_STATS_EN
      if (stat_clear) begin
        expStat0 <= 0;
        expStat1 <= 0;
      end else begin
        if (g[0] && expStat0 < (1 << STAT_W) - 1) expStat0 <= expStat0 + 1;
        if (g[1] && expStat1 < (1 << STAT_W) - 1) expStat1 <= expStat1 + 1;
      end
`endif
    end
  end

  always @(negedge clock) begin
    logic [1:0] g;
    if (started) begin
      g = modelGrant();
      check("req0_ready", req0_ready, g[0]);
      check("req1_ready", req1_ready, g[1]);
      check("alu_opA", alu_opA, g[0] ? req0_opA : g[1] ? req1_opA : '0);
      check("alu_opB", alu_opB, g[0] ? req0_opB : g[1] ? req1_opB : '0);
      check("alu_opcode", alu_opcode, g[0] ? req0_opcode : g[1] ? req1_opcode : '0);
      check("alu_shamt", alu_shamt, g[0] ? req0_shamt : g[1] ? req1_shamt : '0);
      check("rsp_valid", rsp_valid, expValid);
      check("rsp_id", rsp_id, expId);
      check("rsp_result", rsp_result, expRes.r);
      check("rsp_ne", rsp_ne, expRes.ne);
      check("rsp_lt", rsp_lt, expRes.lt);
      check("rsp_ovf", rsp_ovf, expRes.ovf);
`ifdef ALU_ARB_STATS_EN
      check("stat_grant0", stat_grant0, expStat0);
      check("stat_grant1", stat_grant1, expStat1);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(logic v, logic l, logic [4:0] op, logic [4:0] sh, logic [DW-1:0] a, logic [DW-1:0] b);
    req0_valid = v; req0_lock = l; req0_opcode = op; req0_shamt = sh; req0_opA = a; req0_opB = b;
  endtask

  task automatic drive1(logic v, logic l, logic [4:0] op, logic [4:0] sh, logic [DW-1:0] a, logic [DW-1:0] b);
    req1_valid = v; req1_lock = l; req1_opcode = op; req1_shamt = sh; req1_opA = a; req1_opB = b;
  endtask

  initial begin
    cyc();
    cyc();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_result", rsp_result, 0);
    reset = 1'b0;

    // Single ADD from requester 0, then idle cycles.
    drive0(1, 0, OP_ADD, 0, 5, 7);
    #1 check("add_ready0", req0_ready, 1);
    cyc();
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_id", rsp_id, 0);
    check("add_rsp_result", rsp_result, 12);
    check("add_rsp_ovf", rsp_ovf, 0);
    check("idle_alu_opA", alu_opA, 0);
    cyc();
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_rsp_hold", rsp_result, 12);

    // Round-robin from reset with both requesters valid.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(1, 0, OP_ADD, 0, i, 1);
      drive1(1, 0, OP_OR, 0, 32'hF0, i);
      #1;
      check("rr_ready0", req0_ready, (i % 2) == 0);
      check("rr_ready1", req1_ready, (i % 2) == 1);
      if (i > 0) check("rr_rsp_id", rsp_id, (i - 1) % 2);
      cyc();
    end
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    #1;
    check("rr_last_id", rsp_id, 1);
    check("rr_last_result", rsp_result, 32'hF3);

    // Requester 1 locks the ALU for a multi-op sequence.
    drive1(1, 1, OP_SUB, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    #1 check("lk_first_ready1", req1_ready, 1);
    cyc();
    drive0(1, 0, OP_ADD, 0, 3, 4);
    drive1(1, 1, OP_SUB, 0, 10, 3);
    #1;
    check("lk_ready0_a", req0_ready, 0);
    check("lk_ovf", rsp_ovf, 1);
    check("lk_result", rsp_result, 32'h8000_0000);
    cyc();
    drive1(0, 0, 0, 0, 0, 0);
    #1;
    check("lk_idle_ready0", req0_ready, 0);
    check("lk_idle_alu", alu_opA, 0);
    cyc();
    drive1(1, 1, OP_AND, 0, 32'hFF00, 32'h0FF0);
    #1 check("lk_ready0_b", req0_ready, 0);
    cyc();
    drive1(1, 0, OP_OR, 0, 1, 2);
    #1 check("lk_release_ready1", req1_ready, 1);
    cyc();
    drive1(1, 0, OP_SRA, 4, 32'h8000_0000, 0);
    #1;
    check("post_lock_ready0", req0_ready, 1);
    check("post_lock_ready1", req1_ready, 0);
    cyc();
    drive1(0, 0, 0, 0, 0, 0);

    // Reset while requester 0 holds a lock.
    drive0(1, 1, OP_SLL, 31, 1, 0);
    #1 check("sll_ready0", req0_ready, 1);
    cyc();
    reset = 1'b1;
    drive0(0, 0, 0, 0, 0, 0);
    drive1(1, 0, OP_ADD, 0, 9, 9);
    #1;
    check("sll_rsp_result", rsp_result, 32'h8000_0000);
    check("sll_lock_ready1", req1_ready, 0);
    cyc();
    reset = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    drive0(1, 0, OP_ADD, 0, 2, 2);
    #1;
    check("rst_tie_ready0", req0_ready, 1);
    check("rst_tie_ready1", req1_ready, 0);
    cyc();
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    cyc();

`ifdef ALU_ARB_STATS_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive0(1, 0, OP_ADD, 0, i, i);
      cyc();
    end
    drive0(0, 0, 0, 0, 0, 0);
    #1 check("stat_sat", stat_grant0, 3);
    drive0(1, 0, OP_ADD, 0, 1, 1);
    stat_clear = 1'b1;
    cyc();
    stat_clear = 1'b0;
    drive0(0, 0, 0, 0, 0, 0);
    #1 check("stat_clear", stat_grant0, 0);
    cyc();
`endif

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
